ioctl_upload_server: RTL and testbench

Serves HPS upload requests (core-to-HPS direction of the ioctl channel, the counterpart of the ROM download path) by reading bytes out of a core-side memory such as hiscore/NVRAM. It sits between `hps_io` (ioctl_upload/ioctl_rd/ioctl_din/ioctl_wait) and a dual-port RAM shared with the game CPU. It pauses the game while serving, stalls the HPS with `ioctl_wait` across RAM latency, and pads out-of-range addresses.

---
 rtl/ioctl_upload_server_if.sv | 27 ++
 rtl/ioctl_upload_server.sv | 170 +++++++++++++++++
 tb/tb_ioctl_upload_server.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ioctl_upload_server_if.sv
// Port bundles for ioctl_upload_server: the HPS-facing upload channel and the
// core-facing memory/pause port.
interface ioctl_upload_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [15:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;

  modport master (output ioctl_upload, ioctl_rd, ioctl_addr,
                  input  ioctl_din, ioctl_wait);
  modport slave  (input  ioctl_upload, ioctl_rd, ioctl_addr,
                  output ioctl_din, ioctl_wait);
endinterface

interface upload_mem_if #(parameter int AW = 10);
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [7:0]    mem_q;
  logic          pause_req;
  logic          pause_ack;

  modport master (output mem_addr, mem_rd, pause_req,
                  input  mem_q, pause_ack);
  modport slave  (input  mem_addr, mem_rd, pause_req,
                  output mem_q, pause_ack);
endinterface

// File: rtl/ioctl_upload_server.sv
// Serves HPS upload byte requests from a core-side RAM, pausing the core while active.
// Define UPLOAD_CHECKSUM_EN to return the session byte sum at address LEN.
module ioctl_upload_server #(
  parameter int         AW     = 10,
  parameter int         LEN    = 1024,
  parameter int         RD_LAT = 1,
  parameter logic [7:0] PAD    = 8'hFF
) (
  input  logic          clk,
  input  logic          reset,
  ioctl_upload_if.slave hps,
  upload_mem_if.master  mem,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {IDLE, PAUSE, READY, READ, OUT} state_t;

  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic [15:0]   pend_addr_q, pend_addr_d;
  logic [2:0]    lat_cnt_q, lat_cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]    din_q, din_d;
  logic          wait_q, wait_d;
  logic          pause_req_q, pause_req_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          req;
  logic          fire;
  logic          in_range;
  logic [15:0]   req_addr;
  logic [7:0]    tail_byte;

`ifdef UPLOAD_CHECKSUM_EN
  logic [7:0]    sum_q, sum_d;
  logic          is_sum_addr;
`endif

  // The full 16-bit address is compared, so aliases above 2^AW never reach the RAM.
  always_comb begin
    req      = hps.ioctl_upload && (hps.ioctl_rd || pend_q);
    req_addr = pend_q ? pend_addr_q : hps.ioctl_addr;
    in_range = ({1'b0, req_addr} < 17'(LEN));
    fire     = (state_q == READY) && mem.pause_ack && req;
`ifdef UPLOAD_CHECKSUM_EN
    is_sum_addr = ({1'b0, req_addr} == 17'(LEN));
    tail_byte   = is_sum_addr ? sum_q : PAD;
`else
    tail_byte   = PAD;
`endif
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    lat_cnt_d   = lat_cnt_q;
    mem_addr_d  = mem_addr_q;
    din_d       = din_q;
    done_d      = 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
    sum_d       = sum_q;
`endif

    if (state_q != IDLE && !hps.ioctl_upload) begin
      state_d = IDLE;
      pend_d  = 1'b0;
      done_d  = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (hps.ioctl_upload) begin
            state_d = PAUSE;
            pend_d  = 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
            sum_d   = 8'h00;
`endif
          end
        end
        PAUSE: begin
          if (hps.ioctl_rd && !pend_q) begin
            pend_d      = 1'b1;
            pend_addr_d = hps.ioctl_addr;
          end
          if (mem.pause_ack) state_d = READY;
        end
        READY: begin
          if (!mem.pause_ack) begin
            state_d = PAUSE;
            if (hps.ioctl_rd && !pend_q) begin
              pend_d      = 1'b1;
              pend_addr_d = hps.ioctl_addr;
            end
          end else if (req) begin
            pend_d = 1'b0;
            if (in_range) begin
              state_d    = READ;
              lat_cnt_d  = 3'd0;
              mem_addr_d = req_addr[AW-1:0];
            end else begin
              state_d = OUT;
              din_d   = tail_byte;
            end
          end
        end
        READ: begin
          if (lat_cnt_q == 3'(RD_LAT - 1)) begin
            state_d = OUT;
            din_d   = mem.mem_q;
`ifdef UPLOAD_CHECKSUM_EN
            sum_d   = sum_q + mem.mem_q;
`endif
          end else begin
            lat_cnt_d = lat_cnt_q + 3'd1;
          end
        end
        OUT:     state_d = mem.pause_ack ? READY : PAUSE;
        default: state_d = IDLE;
      endcase
    end

    wait_d      = (state_d == PAUSE) || (state_d == READ);
    pause_req_d = (state_d != IDLE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pend_q      <= 1'b0;
      pend_addr_q <= 16'h0000;
      lat_cnt_q   <= 3'd0;
      mem_addr_q  <= '0;
      din_q       <= 8'h00;
      wait_q      <= 1'b0;
      pause_req_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef UPLOAD_CHECKSUM_EN
      sum_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_addr_q  <= mem_addr_d;
      din_q       <= din_d;
      wait_q      <= wait_d;
      pause_req_q <= pause_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef UPLOAD_CHECKSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  // The request cycle itself stalls the HPS combinationally, ahead of the registered wait.
  assign hps.ioctl_wait = wait_q | fire;
  assign hps.ioctl_din  = din_q;
  assign mem.mem_rd     = fire && in_range;
  assign mem.mem_addr   = (fire && in_range) ? req_addr[AW-1:0] : mem_addr_q;
  assign mem.pause_req  = pause_req_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_ioctl_upload_server.sv
// Scoreboard bench for ioctl_upload_server: RD_LAT=1 instance for the main flow,
// RD_LAT=4 instance for abort and asynchronous reset.
module tb_ioctl_upload_server;
  localparam int AW  = 10;
  localparam int LEN = 1024;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ioctl_upload_if        hpsA();
  ioctl_upload_if        hpsB();
  upload_mem_if #(.AW(AW)) memA();
  upload_mem_if #(.AW(AW)) memB();
  logic busyA, doneA, busyB, doneB;

  ioctl_upload_server #(.AW(AW), .LEN(LEN), .RD_LAT(1), .PAD(8'hFF)) dutA (
    .clk(clk), .reset(reset), .hps(hpsA), .mem(memA), .busy(busyA), .done(doneA));
  ioctl_upload_server #(.AW(AW), .LEN(LEN), .RD_LAT(4), .PAD(8'hFF)) dutB (
    .clk(clk), .reset(reset), .hps(hpsB), .mem(memB), .busy(busyB), .done(doneB));

  logic [7:0] ram [0:LEN-1];
  logic [7:0] pipeA = 8'h00;
  logic [7:0] pipeB [0:3] = '{8'h00, 8'h00, 8'h00, 8'h00};
  int memRdCountA = 0;
  int doneCountA  = 0;

  // Behavioural RAMs with one and four clocks of read latency.
  always @(posedge clk) begin
    if (memA.mem_rd) pipeA <= ram[memA.mem_addr];
    pipeB[0] <= memB.mem_rd ? ram[memB.mem_addr] : 8'h00;
    pipeB[1] <= pipeB[0];
    pipeB[2] <= pipeB[1];
    pipeB[3] <= pipeB[2];
    if (memA.mem_rd) memRdCountA <= memRdCountA + 1;
    if (doneA) doneCountA <= doneCountA + 1;
  end
  assign memA.mem_q = pipeA;
  assign memB.mem_q = pipeB[3];

  int         nChecks = 0;
  int         nFail   = 0;
  logic [7:0] sb [$];
  logic [7:0] modelSum;
  logic [7:0] expTail;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One HPS byte request on instance A; returns at the first sample with wait low.
  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] expected,
                               input int expWait, input int expMemRd);
    int waitCnt;
    int guard;
    int rdBefore;
    rdBefore = memRdCountA;
    sb.push_back(expected);
    if (expMemRd != 0) modelSum = modelSum + expected;
    @(posedge clk); #1;
    hpsA.ioctl_rd   = 1'b1;
    hpsA.ioctl_addr = addr;
    @(negedge clk);
    waitCnt = (hpsA.ioctl_wait === 1'b1) ? 1 : 0;
    @(posedge clk); #1;
    hpsA.ioctl_rd = 1'b0;
    guard = 0;
    @(negedge clk);
    while (hpsA.ioctl_wait === 1'b1 && guard < 16) begin
      waitCnt++;
      guard++;
      @(negedge clk);
    end
    checkOutput($sformatf("din@%0h", addr), 32'(hpsA.ioctl_din), 32'(sb.pop_front()));
    checkOutput($sformatf("wait_clks@%0h", addr), 32'(waitCnt), 32'(expWait));
    checkOutput($sformatf("mem_rd_cnt@%0h", addr), 32'(memRdCountA - rdBefore), 32'(expMemRd));
  endtask

  initial begin
    int waitCnt;
    int guard;
    int doneBefore;

    for (int i = 0; i < LEN; i++) ram[i] = 8'(i) ^ 8'h5A;
    reset = 1'b1;
    hpsA.ioctl_upload = 1'b0; hpsA.ioctl_rd = 1'b0; hpsA.ioctl_addr = 16'h0; memA.pause_ack = 1'b0;
    hpsB.ioctl_upload = 1'b0; hpsB.ioctl_rd = 1'b0; hpsB.ioctl_addr = 16'h0; memB.pause_ack = 1'b0;
    modelSum = 8'h00;

    repeat (2) @(negedge clk);
    checkOutput("rst_din",       32'(hpsA.ioctl_din),  0);
    checkOutput("rst_wait",      32'(hpsA.ioctl_wait), 0);
    checkOutput("rst_pause_req", 32'(memA.pause_req),  0);
    checkOutput("rst_busy",      32'(busyA),           0);
    checkOutput("rst_done",      32'(doneA),           0);
    checkOutput("rst_mem_rd",    32'(memA.mem_rd),     0);
    @(posedge clk); #1 reset = 1'b0;

    // Session 1: request latched in PAUSE, ack five clocks later.
    @(posedge clk); #1 hpsA.ioctl_upload = 1'b1;
    @(negedge clk);
    checkOutput("pause_req_same_cycle", 32'(memA.pause_req), 0);
    @(posedge clk); #1;
    hpsA.ioctl_rd = 1'b1; hpsA.ioctl_addr = 16'd3;
    sb.push_back(ram[3]);
    modelSum = modelSum + ram[3];
    @(negedge clk);
    checkOutput("pause_req_next", 32'(memA.pause_req),  1);
    checkOutput("pause_wait",     32'(hpsA.ioctl_wait), 1);
    checkOutput("pause_busy",     32'(busyA),           1);
    @(posedge clk); #1 hpsA.ioctl_rd = 1'b0;
    repeat (4) @(posedge clk);
    #1 memA.pause_ack = 1'b1;
    @(negedge clk);
    checkOutput("pend_wait_ack",   32'(hpsA.ioctl_wait), 1);
    @(negedge clk);
    checkOutput("pend_mem_rd",     32'(memA.mem_rd),     1);
    checkOutput("pend_mem_addr",   32'(memA.mem_addr),   3);
    @(negedge clk);
    checkOutput("pend_wait_read",  32'(hpsA.ioctl_wait), 1);
    @(negedge clk);
    checkOutput("pend_din",        32'(hpsA.ioctl_din),  32'(sb.pop_front()));
    checkOutput("pend_wait_out",   32'(hpsA.ioctl_wait), 0);

    for (int a = 0; a < LEN; a++) applyStimulus(16'(a), ram[a], 2, 1);

`ifdef UPLOAD_CHECKSUM_EN
    expTail = modelSum;
`else
    expTail = 8'hFF;
`endif
    applyStimulus(16'd1024, expTail, 1, 0);
    applyStimulus(16'hFFFF, 8'hFF,   1, 0);
    applyStimulus(16'd1025, 8'hFF,   1, 0);

    // Core reclaims the RAM while idle in READY; request must stall until ack returns.
    @(posedge clk); #1 memA.pause_ack = 1'b0;
    @(posedge clk); #1;
    hpsA.ioctl_rd = 1'b1; hpsA.ioctl_addr = 16'd20;
    sb.push_back(ram[20]);
    @(posedge clk); #1 hpsA.ioctl_rd = 1'b0;
    waitCnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (hpsA.ioctl_wait === 1'b1) waitCnt++;
    end
    checkOutput("ackdrop_wait_hold", 32'(waitCnt), 6);
    @(posedge clk); #1 memA.pause_ack = 1'b1;
    waitCnt = 0;
    guard = 0;
    @(negedge clk);
    while (hpsA.ioctl_wait === 1'b1 && guard < 16) begin
      waitCnt++;
      guard++;
      @(negedge clk);
    end
    checkOutput("ackdrop_din",       32'(hpsA.ioctl_din), 32'(sb.pop_front()));
    checkOutput("ackdrop_wait_clks", 32'(waitCnt),        3);

    doneBefore = doneCountA;
    @(posedge clk); #1 hpsA.ioctl_upload = 1'b0;
    @(negedge clk);
    checkOutput("end_done_early",  32'(doneA),          0);
    checkOutput("end_pause_early", 32'(memA.pause_req), 1);
    @(negedge clk);
    checkOutput("end_done",        32'(doneA),          1);
    checkOutput("end_pause_req",   32'(memA.pause_req), 0);
    checkOutput("end_busy",        32'(busyA),          0);
    @(negedge clk);
    checkOutput("end_done_clear",  32'(doneA),          0);
    checkOutput("end_done_count",  32'(doneCountA - doneBefore), 1);
    memA.pause_ack = 1'b0;

    // Session 2: checksum over a short image.
    ram[0] = 8'h01; ram[1] = 8'h02; ram[2] = 8'h03; ram[3] = 8'hFF;
    modelSum = 8'h00;
    @(posedge clk); #1 hpsA.ioctl_upload = 1'b1;
    @(posedge clk); #1 memA.pause_ack = 1'b1;
    for (int a = 0; a < 4; a++) applyStimulus(16'(a), ram[a], 2, 1);
`ifdef UPLOAD_CHECKSUM_EN
    expTail = 8'h05;
`else
    expTail = 8'hFF;
`endif
    applyStimulus(16'd1024, expTail, 1, 0);
    applyStimulus(16'd1025, 8'hFF,   1, 0);
    @(posedge clk); #1 hpsA.ioctl_upload = 1'b0;
    memA.pause_ack = 1'b0;
    repeat (2) @(posedge clk);

    // Instance B (RD_LAT=4): a normal read first so ioctl_din is non-zero.
    #1 hpsB.ioctl_upload = 1'b1;
    @(posedge clk); #1 memB.pause_ack = 1'b1;
    @(posedge clk); #1;
    hpsB.ioctl_rd = 1'b1; hpsB.ioctl_addr = 16'd9;
    sb.push_back(ram[9]);
    @(negedge clk);
    waitCnt = (hpsB.ioctl_wait === 1'b1) ? 1 : 0;
    @(posedge clk); #1 hpsB.ioctl_rd = 1'b0;
    guard = 0;
    @(negedge clk);
    while (hpsB.ioctl_wait === 1'b1 && guard < 16) begin
      waitCnt++;
      guard++;
      @(negedge clk);
    end
    checkOutput("lat4_din",       32'(hpsB.ioctl_din), 32'(sb.pop_front()));
    checkOutput("lat4_wait_clks", 32'(waitCnt),        5);

    // Upload drops mid-READ: no din update, pause_req/done follow next cycle.
    @(posedge clk); #1;
    hpsB.ioctl_rd = 1'b1; hpsB.ioctl_addr = 16'd7;
    @(posedge clk); #1 hpsB.ioctl_rd = 1'b0;
    @(posedge clk); #1 hpsB.ioctl_upload = 1'b0;
    @(negedge clk);
    checkOutput("abort_pause_early", 32'(memB.pause_req), 1);
    checkOutput("abort_done_early",  32'(doneB),          0);
    @(negedge clk);
    checkOutput("abort_pause_req",   32'(memB.pause_req), 0);
    checkOutput("abort_done",        32'(doneB),          1);
    checkOutput("abort_busy",        32'(busyB),          0);
    checkOutput("abort_din_hold",    32'(hpsB.ioctl_din), 32'(ram[9]));
    repeat (4) @(negedge clk);
    checkOutput("abort_din_late",    32'(hpsB.ioctl_din), 32'(ram[9]));
    checkOutput("abort_done_clear",  32'(doneB),          0);

    // Asynchronous reset in the middle of a READ.
    @(posedge clk); #1 hpsB.ioctl_upload = 1'b1;
    @(posedge clk); #1 memB.pause_ack = 1'b1;
    @(posedge clk); #1;
    hpsB.ioctl_rd = 1'b1; hpsB.ioctl_addr = 16'd5;
    @(posedge clk); #1 hpsB.ioctl_rd = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_wait",  32'(hpsB.ioctl_wait), 1);
    checkOutput("pre_rst_pause", 32'(memB.pause_req),  1);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst_din",       32'(hpsB.ioctl_din),  0);
    checkOutput("arst_wait",      32'(hpsB.ioctl_wait), 0);
    checkOutput("arst_pause_req", 32'(memB.pause_req),  0);
    checkOutput("arst_busy",      32'(busyB),           0);
    checkOutput("arst_done",      32'(doneB),           0);
    checkOutput("arst_mem_rd",    32'(memB.mem_rd),     0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
